// File: rtl/tetris_piece_sequencer_if.sv
// rtl/tetris_piece_sequencer_if.sv - sequencer control/board bus; master drives game inputs, slave is the sequencer
// Optional NEXT_PIECE_PREVIEW_EN adds the next_piece signal.
interface tetris_piece_sequencer_if;
   logic             start;
   logic [6:0]       lock_req;
   logic [3:0][4:0]  cell_row;
   logic [3:0][3:0]  cell_col;
   logic [2:0]       cell_color;
   logic             spawn_blocked;
   logic             clear_done;
   logic [6:0]       piece_go;
   logic             board_we;
   logic [4:0]       board_row;
   logic [3:0]       board_col;
   logic [2:0]       board_color;
   logic             clear_req;
   logic             board_wipe;
   logic [2:0]       game_state;
   logic [15:0]      piece_count;
   logic [1:0]       err_flags;
`ifdef NEXT_PIECE_PREVIEW_EN
   logic [2:0]       next_piece;
`endif

   modport master (
`ifdef NEXT_PIECE_PREVIEW_EN
      input  next_piece,
`endif
      output start, lock_req, cell_row, cell_col, cell_color, spawn_blocked, clear_done,
      input  piece_go, board_we, board_row, board_col, board_color, clear_req,
      input  board_wipe, game_state, piece_count, err_flags
   );

   modport slave (
`ifdef NEXT_PIECE_PREVIEW_EN
      output next_piece,
`endif
      input  start, lock_req, cell_row, cell_col, cell_color, spawn_blocked, clear_done,
      output piece_go, board_we, board_row, board_col, board_color, clear_req,
      output board_wipe, game_state, piece_count, err_flags
   );
endinterface

// File: rtl/tetris_piece_sequencer.sv
// rtl/tetris_piece_sequencer.sv - game sequencer: LFSR spawn, lock arbitration, board write, row-clear handoff
// Optional NEXT_PIECE_PREVIEW_EN adds a one-deep lookahead shown on next_piece.
module tetris_piece_sequencer #(
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          BOARD_ROWS = 20,
   parameter int          BOARD_COLS = 10
) (
   input logic                       clk_i,
   input logic                       reset_i,
   tetris_piece_sequencer_if.slave   seq_if
);
   typedef enum logic [2:0] {
      S_IDLE, S_SPAWN, S_FALL, S_WRITE, S_CLEAR, S_GAME_OVER
   } state_t;

   localparam logic [5:0] ROW_LIM = 6'(BOARD_ROWS);
   localparam logic [4:0] COL_LIM = 5'(BOARD_COLS);

   state_t           state_q;
   logic [15:0]      lfsr_q, lfsr_d;
   logic [1:0]       widx_q;
   logic [3:0][4:0]  cell_row_q;
   logic [3:0][3:0]  cell_col_q;
   logic [2:0]       cell_color_q;
   logic [6:0]       piece_go_q;
   logic             board_we_q;
   logic [4:0]       board_row_q;
   logic [3:0]       board_col_q;
   logic [2:0]       board_color_q;
   logic             clear_req_q;
   logic             board_wipe_q;
   logic [2:0]       game_state_q;
   logic [15:0]      piece_count_q;
   logic [1:0]       err_q;
   logic [2:0]       lfsr_idx;
   logic [2:0]       spawn_idx;
   logic             lock_multi;
   logic [4:0]       cur_row;
   logic [3:0]       cur_col;
   logic             cell_ok;
`ifdef NEXT_PIECE_PREVIEW_EN
   logic [2:0]       look_q;
`endif

   always_comb begin
      lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      lfsr_idx   = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
`ifdef NEXT_PIECE_PREVIEW_EN
      spawn_idx  = look_q;
`else
      spawn_idx  = lfsr_idx;
`endif
      lock_multi = |(seq_if.lock_req & (seq_if.lock_req - 7'd1));
      cur_row    = cell_row_q[widx_q];
      cur_col    = cell_col_q[widx_q];
      cell_ok    = ({1'b0, cur_row} < ROW_LIM) && ({1'b0, cur_col} < COL_LIM);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= S_IDLE;
         lfsr_q        <= LFSR_SEED;
         widx_q        <= 2'd0;
         cell_row_q    <= '0;
         cell_col_q    <= '0;
         cell_color_q  <= 3'd0;
         piece_go_q    <= 7'd0;
         board_we_q    <= 1'b0;
         board_row_q   <= 5'd0;
         board_col_q   <= 4'd0;
         board_color_q <= 3'd0;
         clear_req_q   <= 1'b0;
         board_wipe_q  <= 1'b0;
         game_state_q  <= 3'b000;
         piece_count_q <= 16'd0;
         err_q         <= 2'b00;
`ifdef NEXT_PIECE_PREVIEW_EN
         look_q        <= 3'd0;
`endif
      end else begin
         piece_go_q   <= 7'd0;
         board_we_q   <= 1'b0;
         clear_req_q  <= 1'b0;
         board_wipe_q <= 1'b0;
         // Stray lock requests are flagged here; the restart branch below clears flags last.
         if (state_q != S_FALL && seq_if.lock_req != 7'd0)
            err_q[1] <= 1'b1;

         case (state_q)
            S_IDLE: begin
               if (seq_if.start) begin
                  state_q      <= S_SPAWN;
                  game_state_q <= 3'b001;
`ifdef NEXT_PIECE_PREVIEW_EN
                  look_q       <= lfsr_idx;
                  lfsr_q       <= lfsr_d;
`endif
               end
            end
            S_SPAWN: begin
               lfsr_q <= lfsr_d;
               if (seq_if.spawn_blocked) begin
                  state_q      <= S_GAME_OVER;
                  game_state_q <= 3'b010;
               end else begin
                  piece_go_q <= 7'd1 << spawn_idx;
                  state_q    <= S_FALL;
`ifdef NEXT_PIECE_PREVIEW_EN
                  look_q     <= lfsr_idx;
`endif
               end
            end
            S_FALL: begin
               if (seq_if.lock_req != 7'd0) begin
                  if (lock_multi)
                     err_q[1] <= 1'b1;
                  cell_row_q   <= seq_if.cell_row;
                  cell_col_q   <= seq_if.cell_col;
                  cell_color_q <= seq_if.cell_color;
                  widx_q       <= 2'd0;
                  state_q      <= S_WRITE;
               end
            end
            S_WRITE: begin
               board_row_q   <= cur_row;
               board_col_q   <= cur_col;
               board_color_q <= cell_color_q;
               board_we_q    <= cell_ok;
               if (!cell_ok)
                  err_q[0] <= 1'b1;
               widx_q <= widx_q + 2'd1;
               if (widx_q == 2'd3) begin
                  if (piece_count_q != 16'hFFFF)
                     piece_count_q <= piece_count_q + 16'd1;
                  clear_req_q <= 1'b1;
                  state_q     <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               if (seq_if.clear_done)
                  state_q <= S_SPAWN;
            end
            S_GAME_OVER: begin
               if (seq_if.start) begin
                  board_wipe_q  <= 1'b1;
                  piece_count_q <= 16'd0;
                  err_q         <= 2'b00;
                  state_q       <= S_SPAWN;
                  game_state_q  <= 3'b001;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign seq_if.piece_go    = piece_go_q;
   assign seq_if.board_we    = board_we_q;
   assign seq_if.board_row   = board_row_q;
   assign seq_if.board_col   = board_col_q;
   assign seq_if.board_color = board_color_q;
   assign seq_if.clear_req   = clear_req_q;
   assign seq_if.board_wipe  = board_wipe_q;
   assign seq_if.game_state  = game_state_q;
   assign seq_if.piece_count = piece_count_q;
   assign seq_if.err_flags   = err_q;
`ifdef NEXT_PIECE_PREVIEW_EN
   assign seq_if.next_piece  = look_q;
`endif
endmodule
